// File: rtl/branch_predict_cmp_pkg.sv
// Shared branch type codes and 2-bit counter encodings for the branch
// resolution / direction prediction block.
package branch_predict_cmp_pkg;

   localparam int BR_TYPE_W = 4;

   typedef enum logic [BR_TYPE_W-1:0] {
      BR_NONE = 4'd0,
      BR_BEQ  = 4'd1,
      BR_BNE  = 4'd2,
      BR_BLEZ = 4'd3,
      BR_BGTZ = 4'd4,
      BR_BLTZ = 4'd5,
      BR_BGEZ = 4'd6
   } br_type_e;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt_e;

   // Codes 7..15 are reserved and behave like BR_NONE.
   function automatic logic is_branch_code(input logic [BR_TYPE_W-1:0] code);
      return (code >= BR_BEQ) && (code <= BR_BGEZ);
   endfunction

endpackage

// File: rtl/branch_predict_cmp_cond.sv
// Combinational D-stage branch comparator; zero-compare types test rd1
// against constant 0 and ignore rd2.
module branch_cond
   import branch_predict_cmp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [BR_TYPE_W-1:0] branch,
   input  logic [WIDTH-1:0]     rd1,
   input  logic [WIDTH-1:0]     rd2,
   output logic                 cond
);

   logic is_neg;
   logic is_zero;

   assign is_neg  = rd1[WIDTH-1];
   assign is_zero = (rd1 == '0);

   always_comb begin
      cond = 1'b0;
      case (branch)
         BR_BEQ:  cond = (rd1 == rd2);
         BR_BNE:  cond = (rd1 != rd2);
         BR_BLEZ: cond = is_neg | is_zero;
         BR_BGTZ: cond = ~is_neg & ~is_zero;
         BR_BLTZ: cond = is_neg;
         BR_BGEZ: cond = ~is_neg;
         default: cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_cmp.sv
// Branch resolution at D merged with a PC-indexed table of 2-bit saturating
// direction counters read asynchronously at F, plus saturating statistics.
module branch_predict_cmp
   import branch_predict_cmp_pkg::*;
#(
   parameter int         WIDTH      = 32,
   parameter int         PC_WIDTH   = 32,
   parameter int         BHT_DEPTH  = 64,
   parameter logic [1:0] CNT_INIT   = 2'b01,
   parameter int         STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PC_WIDTH-1:0]   f_pc,
   input  logic                  f_is_branch,
   output logic                  f_pred_taken,
   input  logic                  d_valid,
   input  logic                  d_stall,
   input  logic [PC_WIDTH-1:0]   d_pc,
   input  logic [BR_TYPE_W-1:0]  d_branch,
   input  logic [WIDTH-1:0]      d_rd1,
   input  logic [WIDTH-1:0]      d_rd2,
   input  logic                  d_pred_taken,
   output logic                  d_taken,
   output logic                  d_mispredict,
   output logic [STAT_WIDTH-1:0] br_count,
   output logic [STAT_WIDTH-1:0] mis_count
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]       bht [BHT_DEPTH];
   logic [IDX_W-1:0] f_idx;
   logic [IDX_W-1:0] d_idx;
   logic             cond;
   logic             is_br;
   logic             upd;
   logic [1:0]       cur_cnt;
   logic [1:0]       nxt_cnt;
   logic             unused_pc;

   branch_cond #(.WIDTH(WIDTH)) u_cond (
      .branch (d_branch),
      .rd1    (d_rd1),
      .rd2    (d_rd2),
      .cond   (cond)
   );

   // Word-aligned PCs: drop the byte offset; higher bits alias by design.
   assign f_idx     = f_pc[IDX_W+1:2];
   assign d_idx     = d_pc[IDX_W+1:2];
   assign unused_pc = ^{f_pc[PC_WIDTH-1:IDX_W+2], f_pc[1:0],
                        d_pc[PC_WIDTH-1:IDX_W+2], d_pc[1:0]};

   assign is_br        = d_valid & is_branch_code(d_branch);
   assign d_taken      = is_br & cond;
   assign d_mispredict = is_br & (d_taken ^ d_pred_taken);
   assign f_pred_taken = f_is_branch & bht[f_idx][1];

   assign upd     = is_br & ~d_stall;
   assign cur_cnt = bht[d_idx];

   always_comb begin
      nxt_cnt = cur_cnt;
      if (d_taken) begin
         if (cur_cnt != ST) nxt_cnt = cur_cnt + 2'd1;
      end else begin
         if (cur_cnt != SNT) nxt_cnt = cur_cnt - 2'd1;
      end
   end

   // Stall holds everything so a frozen branch is trained and counted once.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= CNT_INIT;
         br_count  <= '0;
         mis_count <= '0;
      end else if (upd) begin
         bht[d_idx] <= nxt_cnt;
         if (br_count != '1) br_count <= br_count + STAT_WIDTH'(1);
         if (d_mispredict && (mis_count != '1)) mis_count <= mis_count + STAT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_predict_cmp.sv
// Self-checking bench for branch_predict_cmp: directed sequences, a vector
// table for the comparator, and randomized traffic against a reference model.
module tb_branch_predict_cmp;

   localparam int DEPTH = 64;

   logic        clk;
   logic        reset;
   logic [31:0] f_pc;
   logic        f_is_branch;
   logic        f_pred_taken;
   logic        d_valid;
   logic        d_stall;
   logic [31:0] d_pc;
   logic [3:0]  d_branch;
   logic [31:0] d_rd1;
   logic [31:0] d_rd2;
   logic        d_pred_taken;
   logic        d_taken;
   logic        d_mispredict;
   logic [31:0] br_count;
   logic [31:0] mis_count;

   branch_predict_cmp dut (
      .clk          (clk),
      .reset        (reset),
      .f_pc         (f_pc),
      .f_is_branch  (f_is_branch),
      .f_pred_taken (f_pred_taken),
      .d_valid      (d_valid),
      .d_stall      (d_stall),
      .d_pc         (d_pc),
      .d_branch     (d_branch),
      .d_rd1        (d_rd1),
      .d_rd2        (d_rd2),
      .d_pred_taken (d_pred_taken),
      .d_taken      (d_taken),
      .d_mispredict (d_mispredict),
      .br_count     (br_count),
      .mis_count    (mis_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard
   logic [31:0] exp_q[$];
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      logic [31:0] e;
      exp_q.push_back(exp);
      e = exp_q.pop_front();
      n_total++;
      if (act === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, e);
   endtask

   // reference model: counters as integers 0..3, statistics as plain counts
   int          m_cnt [DEPTH];
   longint      m_br;
   longint      m_mis;

   function automatic int ref_idx(input logic [31:0] pc);
      return int'((pc / 4) % DEPTH);
   endfunction

   function automatic logic ref_cond(input int br, input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = int'(signed'(a));
      case (br)
         1: return a == b;
         2: return a != b;
         3: return sa <= 0;
         4: return sa > 0;
         5: return sa < 0;
         6: return sa >= 0;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic ref_is_br();
      return d_valid && (d_branch >= 1) && (d_branch <= 6);
   endfunction

   function automatic logic ref_taken();
      return ref_is_br() && ref_cond(int'(d_branch), d_rd1, d_rd2);
   endfunction

   function automatic logic ref_pred();
      return f_is_branch && (m_cnt[ref_idx(f_pc)] >= 2);
   endfunction

   function automatic logic [31:0] sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
   endfunction

   // one clock: check combinational outputs, advance model at the edge, check state
   task automatic tick();
      logic tk, is_br, mis;
      int   k;
      #1;
      is_br = ref_is_br();
      tk    = ref_taken();
      mis   = is_br && (tk != d_pred_taken);
      check("d_taken", {31'd0, d_taken}, {31'd0, tk});
      check("d_mispredict", {31'd0, d_mispredict}, {31'd0, mis});
      check("f_pred_taken", {31'd0, f_pred_taken}, {31'd0, ref_pred()});
      @(posedge clk);
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) m_cnt[i] = 1;
         m_br  = 0;
         m_mis = 0;
      end else if (is_br && !d_stall) begin
         k = ref_idx(d_pc);
         m_cnt[k] = tk ? ((m_cnt[k] < 3) ? m_cnt[k] + 1 : 3)
                       : ((m_cnt[k] > 0) ? m_cnt[k] - 1 : 0);
         m_br++;
         if (mis) m_mis++;
      end
      #1;
      check("br_count", br_count, sat32(m_br));
      check("mis_count", mis_count, sat32(m_mis));
   endtask

   // driver
   task automatic drive_d(input logic v, input logic st, input logic [31:0] pc,
                          input logic [3:0] br, input logic [31:0] a,
                          input logic [31:0] b, input logic pred);
      d_valid      = v;
      d_stall      = st;
      d_pc         = pc;
      d_branch     = br;
      d_rd1        = a;
      d_rd2        = b;
      d_pred_taken = pred;
   endtask

   typedef struct {
      logic [3:0]  br;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        valid;
      logic        pred;
      logic        exp_taken;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [10];

   initial begin
      logic [31:0] br_hold, mis_hold;
      logic [31:0] pcs [4];

      vecs[0] = '{4'd6, 32'hFFFF_FFFF, 32'd0,       1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'd3, 32'd0,         32'd7,       1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{4'd4, 32'h7FFF_FFFF, 32'd0,       1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{4'd5, 32'h8000_0000, 32'd0,       1'b1, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{4'd9, 32'd5,         32'd5,       1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{4'd2, 32'd5,         32'd6,       1'b1, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{4'd1, 32'd5,         32'd6,       1'b1, 1'b1, 1'b0, 1'b1};
      vecs[7] = '{4'd1, 32'd5,         32'd5,       1'b0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{4'd4, 32'd0,         32'd9,       1'b1, 1'b0, 1'b0, 1'b0};
      vecs[9] = '{4'd0, 32'd0,         32'd0,       1'b1, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < DEPTH; i++) m_cnt[i] = 1;
      m_br = 0;
      m_mis = 0;
      reset       = 1'b0;
      f_pc        = 32'h0;
      f_is_branch = 1'b0;
      drive_d(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0);

      // reset for two cycles
      tick();
      tick();
      reset       = 1'b1;
      f_is_branch = 1'b1;
      f_pc        = 32'h1234;
      #1;
      check("reset_pred", {31'd0, f_pred_taken}, 32'd0);
      check("reset_br", br_count, 32'd0);
      check("reset_mis", mis_count, 32'd0);

      // first taken BEQ mispredicts and trains 01 -> 10
      f_pc = 32'h3000;
      drive_d(1'b1, 1'b0, 32'h3000, 4'd1, 32'd5, 32'd5, 1'b0);
      #1;
      check("beq_taken", {31'd0, d_taken}, 32'd1);
      check("beq_mis", {31'd0, d_mispredict}, 32'd1);
      check("beq_rdw_pred", {31'd0, f_pred_taken}, 32'd0);
      tick();
      check("beq_trained_pred", {31'd0, f_pred_taken}, 32'd1);
      check("beq_br", br_count, 32'd1);
      check("beq_mis_cnt", mis_count, 32'd1);

      // saturate at 11, then walk down
      drive_d(1'b1, 1'b0, 32'h3000, 4'd1, 32'd5, 32'd5, 1'b1);
      repeat (3) tick();
      drive_d(1'b1, 1'b0, 32'h3000, 4'd1, 32'd5, 32'd6, 1'b1);
      tick();
      check("nt1_pred", {31'd0, f_pred_taken}, 32'd1);
      tick();
      check("nt2_pred", {31'd0, f_pred_taken}, 32'd0);
      check("seq_br", br_count, 32'd6);
      check("seq_mis", mis_count, 32'd3);

      // comparator vector table
      f_pc = 32'h0100;
      for (int i = 0; i < 10; i++) begin
         drive_d(vecs[i].valid, 1'b0, 32'h0100, vecs[i].br, vecs[i].rd1, vecs[i].rd2, vecs[i].pred);
         #1;
         check($sformatf("vec%0d_taken", i), {31'd0, d_taken}, {31'd0, vecs[i].exp_taken});
         check($sformatf("vec%0d_mis", i), {31'd0, d_mispredict}, {31'd0, vecs[i].exp_mis});
         tick();
      end

      // stalled mispredicting branch is counted once
      br_hold  = br_count;
      mis_hold = mis_count;
      f_pc = 32'h0200;
      drive_d(1'b1, 1'b1, 32'h0200, 4'd2, 32'd1, 32'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_mis", {31'd0, d_mispredict}, 32'd1);
         tick();
         check("stall_br_hold", br_count, br_hold);
         check("stall_mis_hold", mis_count, mis_hold);
         check("stall_pred_hold", {31'd0, f_pred_taken}, 32'd0);
      end
      d_stall = 1'b0;
      tick();
      check("unstall_br", br_count, br_hold + 32'd1);
      check("unstall_mis", mis_count, mis_hold + 32'd1);
      check("unstall_pred", {31'd0, f_pred_taken}, 32'd1);

      // aliasing: 0x3100 shares the entry of 0x3000
      drive_d(1'b1, 1'b0, 32'h3000, 4'd1, 32'd7, 32'd7, 1'b0);
      tick();
      tick();
      f_pc = 32'h3100;
      #1;
      check("alias_pred", {31'd0, f_pred_taken}, 32'd1);

      // reset beats a simultaneous update
      reset = 1'b0;
      tick();
      reset = 1'b1;
      f_pc  = 32'h3000;
      drive_d(1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0);
      #1;
      check("rst_pred", {31'd0, f_pred_taken}, 32'd0);
      check("rst_br", br_count, 32'd0);
      check("rst_mis", mis_count, 32'd0);

      // randomized traffic against the model
      pcs[0] = 32'h3000;
      pcs[1] = 32'h3100;
      pcs[2] = 32'h0404;
      pcs[3] = 32'h0008;
      for (int i = 0; i < 400; i++) begin
         reset       = ($urandom_range(0, 59) != 0);
         f_is_branch = 1'($urandom_range(0, 1));
         f_pc        = pcs[$urandom_range(0, 3)];
         drive_d(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                 pcs[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 2)) : $urandom,
                 32'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_predict_cmp.md
Name: branch_predict_cmp

Overview:
Next-generation branch resolution block for the pipelined MIPS core. It merges the D-stage branch comparator (parametrised width, all zero-compare branches against constant 0) with a PC-indexed table of 2-bit saturating counters that predicts branch direction in F. It flags mispredicts at D so hazard/flush logic can redirect, and keeps saturating branch and mispredict counters for performance inspection.

Parameters:
WIDTH, 32, operand width of rd1/rd2
PC_WIDTH, 32, PC width
BHT_DEPTH, 64, number of counter entries; power of two, >= 2
CNT_INIT, 2'b01, counter value after reset (weakly not-taken)
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-low reset (reset==0 resets at the clk edge)
f_pc  input  PC_WIDTH  F-stage PC
f_is_branch  input  1  predecode: F instruction is a conditional branch
f_pred_taken  output  1  predicted direction for the F instruction
d_valid  input  1  D-stage instruction is valid (not a bubble)
d_stall  input  1  D stage frozen this cycle
d_pc  input  PC_WIDTH  D-stage PC
d_branch  input  4  branch type code (shared package)
d_rd1  input  WIDTH  forwarded rs value
d_rd2  input  WIDTH  forwarded rt value
d_pred_taken  input  1  prediction carried down from F
d_taken  output  1  actual branch outcome
d_mispredict  output  1  actual != predicted
br_count  output  STAT_WIDTH  resolved branches
mis_count  output  STAT_WIDTH  mispredicted branches

Behaviour:
- Codes: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6. 7..15 are treated as NONE.
- Condition (combinational, signed): BEQ rd1==rd2; BNE rd1!=rd2; BLEZ rd1<=0; BGTZ rd1>0; BLTZ rd1<0; BGEZ rd1>=0. d_rd2 is ignored for all four zero-compare types.
- is_br = d_valid & (d_branch in 1..6).
- d_taken = is_br & cond.
- d_mispredict = is_br & (d_taken != d_pred_taken).
- Both outputs are combinational and are valid even when d_stall=1.
- Index = pc[IDX_W+1:2], where IDX_W = log2(BHT_DEPTH). PCs 4*BHT_DEPTH bytes apart alias to the same entry; this is intended.
- f_pred_taken = f_is_branch & bht[idx(f_pc)][1]. This is an asynchronous read.
- Read-during-write to the same index returns the pre-update value. No bypass.
- Update at clk edge when reset=1 & is_br & !d_stall:
  - taken: cnt = (cnt==3) ? 3 : cnt+1
  - not taken: cnt = (cnt==0) ? 0 : cnt-1
  - br_count += 1, saturating at all-ones.
  - mis_count += 1 if d_mispredict, saturating at all-ones.
- d_stall=1 blocks all state updates, so a held branch is counted exactly once.
- Reset (reset==0 at edge): every counter = CNT_INIT, br_count = mis_count = 0. Reset overrides a simultaneous update.
- Reset output values: f_pred_taken = f_is_branch & CNT_INIT[1]; statistics = 0. d_* outputs depend only on inputs.
- Latency: prediction in the same cycle; resolution in the same cycle; a table update is visible to F one cycle after the D edge.
- No X propagation: every combinational path has a default arm.

Decomposition:
- Shared header/package: branch type codes (BR_NONE..BR_BGEZ), counter encodings (SNT=00, WNT=01, WT=10, ST=11), BR_TYPE_W=4.
- One natural sub-module: branch_cond. It is purely combinational and takes d_branch, d_rd1, d_rd2 to produce cond.
- Counter table, saturation logic and statistics live in the top.

Test Plan:
1. Reset low for 2 cycles, then high; f_is_branch=1, any f_pc -> f_pred_taken=0, br_count=0, mis_count=0.
2. BEQ, pc=0x3000, rd1=rd2=5, pred=0 -> d_taken=1, d_mispredict=1. Next cycle with f_pc=0x3000 -> f_pred_taken=1; br_count=1, mis_count=1.
3. Three more taken BEQ at 0x3000 -> counter 11, stays 11. One not-taken -> 10, f_pred_taken still 1. A second not-taken -> 01, f_pred_taken=0.
4. BGEZ rd1=0xFFFFFFFF -> d_taken=0. BLEZ rd1=0, rd2=7 -> d_taken=1. BGTZ rd1=0x7FFFFFFF -> 1. BLTZ rd1=0x80000000 -> 1. Code 9 -> d_taken=0, no counter change.
5. Valid mispredicting branch with d_stall=1 for 3 cycles -> d_mispredict=1 each cycle, counters unchanged. Drop stall -> br_count and mis_count +1 only.
6. Aliasing and reset: train pc 0x3000 to taken -> f_pc=0x3100 (BHT_DEPTH=64) predicts taken. Pull reset low while a valid branch sits in D -> entry returns to 01, statistics 0, no update that cycle.
